// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore control sequencer for the multi-cycle MIPS datapath. Each instruction
// is stepped through fetch, decode, execute, memory and write-back states,
// and the datapath enables and mux selects are decoded from the state
// register alone.
//
// Optional feature: define MC_WAIT_EN to make FETCH, MEM_READ and MEM_WRITE
// stall until mem_ready=1 is sampled. Without it, mem_ready is ignored and
// every state lasts exactly one cycle.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode[5:0]       Instruction[31:26] from the instruction register
//   zero              ALU zero flag (the datapath ANDs it with PCWriteCond)
//   mem_ready         memory completion handshake (MC_WAIT_EN only)
//   PCWrite .. PCSource  datapath strobes and selects
//   illegal_op        one-cycle pulse in DECODE on an unsupported opcode
//   state[3:0]        current state encoding, for debug
//   retired[CNT_W-1:0] completed instruction count, wraps
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDest,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] retired_reg, retired_next;
    logic             retire_tick;
    logic             mem_ok;

    // mem_ok marks the cycle in which a memory-facing state may complete.
`ifdef MC_WAIT_EN
    assign mem_ok = mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ok           = 1'b1;
    assign mem_ready_unused = mem_ready;
`endif

    // The branch decision is made in the datapath (PCWriteCond & zero), so
    // the controller itself never looks at the flag.
    logic zero_unused;
    assign zero_unused = zero;

    logic op_legal;
    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
            default:                                       op_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and retired-count registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            retired_reg <= retired_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and retirement
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        retire_tick = 1'b0;
        case (state_reg)
            S_FETCH:     state_next = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_next = mem_ok ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                state_next  = mem_ok ? S_FETCH : S_MEM_WRITE;
                retire_tick = mem_ok;
            end
            S_EXECUTE:   state_next = S_R_WB;
            S_ADDI_EX:   state_next = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_next  = S_FETCH;
                retire_tick = 1'b1;
            end
            default:     state_next = S_FETCH;
        endcase
        retired_next = retired_reg + {{(CNT_W-1){1'b0}}, retire_tick};
    end

    // -------------------------------------------------------------------------
    // Moore output decode; everything is held at 0 while reset is high so no
    // strobe from an aborted instruction reaches the datapath.
    // -------------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDest     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'd0;
        ALUOp       = 2'b00;
        PCSource    = 2'd0;
        illegal_op  = 1'b0;
        if (!reset) begin
            case (state_reg)
                S_FETCH: begin
                    MemRead = 1'b1;
                    // Load PC/IR only on the completing cycle so the PC
                    // advances once per fetch even across wait states.
                    IRWrite = mem_ok;
                    PCWrite = mem_ok;
                    ALUSrcB = 2'd1;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'd3;
                    illegal_op = ~op_legal;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                end
                S_MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                S_MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_R_WB: begin
                    RegWrite = 1'b1;
                    RegDest  = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'd1;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'd2;
                end
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'd2;
                end
                S_ADDI_WB: begin
                    RegWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_controller. A reference model builds the expected
// state path of each instruction from the opcode, expands memory waits from
// the sampled mem_ready, and predicts the control word per state and the
// retired count.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

`ifdef MC_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemToReg, RegDest, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] retired;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_retired = 0;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDest(RegDest), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state(state),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Control word layout:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDest,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]}
    function automatic logic [15:0] ctrl_word();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                RegDest, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
    endfunction

    // Expected control word per state, written from the state table.
    function automatic logic [15:0] exp_ctrl(input int s, input bit rdy);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        bit m2r = 0, rdst = 0, rwr = 0, srca = 0;
        logic [1:0] srcb = 0, aop = 0, psrc = 0;
        bit fetch_done = !WAIT_EN || rdy;
        case (s)
            0:  begin mrd = 1; irw = fetch_done; pcw = fetch_done; srcb = 1; end
            1:  srcb = 3;
            2:  begin srca = 1; srcb = 2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rwr = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rwr = 1; rdst = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 1; end
            9:  begin pcw = 1; psrc = 2; end
            10: begin srca = 1; srcb = 2; end
            11: rwr = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, psrc};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Expected state path of one instruction (without memory waits).
    function automatic void build_path(input logic [5:0] op, output int path[$]);
        path = {0, 1};
        case (op)
            6'b100011: path = {0, 1, 2, 3, 4};
            6'b101011: path = {0, 1, 2, 5};
            6'b000000: path = {0, 1, 6, 7};
            6'b001000: path = {0, 1, 10, 11};
            6'b000100: path = {0, 1, 8};
            6'b000010: path = {0, 1, 9};
            default:   path = {0, 1};
        endcase
    endfunction

    // Check one cycle (inputs already driven), then advance past the edge.
    task automatic step(input int s, input bit illegal, input bit rdy, input string name);
        @(negedge clk);
        check({name, ".state"}, {28'd0, state}, s);
        check({name, ".ctrl"}, {16'd0, ctrl_word()}, {16'd0, exp_ctrl(s, rdy)});
        check({name, ".illegal_op"}, {31'd0, illegal_op}, {31'd0, (s == 1) && illegal});
        check({name, ".retired"}, retired, exp_retired);
        $display("cycle op=%b state=%0d rdy=%0b retired=%0d", opcode, state, rdy, retired);
        @(posedge clk); #1;
    endtask

    // Two reset cycles starting from expected state first_state.
    task automatic do_reset(input int first_state);
        reset = 1'b1;
        @(negedge clk);
        check("rst1.state", {28'd0, state}, first_state);
        check("rst1.ctrl", {16'd0, ctrl_word()}, 32'd0);
        check("rst1.illegal_op", {31'd0, illegal_op}, 32'd0);
        check("rst1.retired", retired, exp_retired);
        @(posedge clk); #1;
        exp_retired = 0;
        @(negedge clk);
        check("rst2.state", {28'd0, state}, 32'd0);
        check("rst2.ctrl", {16'd0, ctrl_word()}, 32'd0);
        check("rst2.retired", retired, exp_retired);
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset done state=%0d retired=%0d", state, retired);
    endtask

    // Run one instruction; abort_at >= 0 asserts reset in that path step.
    task automatic run_instr(input logic [5:0] op, input bit z, input int abort_at, input int rdy_pct);
        int  path[$];
        bit  illegal = !is_legal(op);
        bit  held;
        build_path(op, path);
        opcode = op;
        zero   = z;
        for (int i = 0; i < path.size(); i++) begin
            if (i == abort_at) begin
                mem_ready = 1'($urandom_range(0, 1));
                do_reset(path[i]);
                return;
            end
            do begin
                mem_ready = ($urandom_range(0, 99) < rdy_pct);
                held = WAIT_EN && (path[i] inside {0, 3, 5}) && !mem_ready;
                step(path[i], illegal, mem_ready, $sformatf("op%b.s%0d", op, path[i]));
            end while (held);
        end
        if (!illegal) exp_retired++;
        $display("instr op=%b done retired_exp=%0d", op, exp_retired);
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] r;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        reset     = 1'b1;
        opcode    = 6'($urandom);
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        // Initial reset from power-up, then the first FETCH strobes.
        do_reset(0);
        run_instr(6'b100011, 1'b0, -1, 100);          // lw
        run_instr(6'b000100, 1'b1, -1, 100);          // beq taken
        run_instr(6'b000100, 1'b0, -1, 100);          // beq not taken
        run_instr(6'b111111, 1'b0, -1, 100);          // illegal
        run_instr(6'b101011, 1'b0, 3, 100);           // sw aborted in MEM_WRITE
        run_instr(6'b101011, 1'b0, -1, 100);          // sw complete
        run_instr(6'b100011, 1'b0, 2, 100);           // lw aborted in MEM_ADDR
        run_instr(6'b100011, 1'b0, -1, 20);           // lw with likely waits
        // Random instruction mix with random handshake.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do begin
                    r = 6'($urandom);
                end while (is_legal(r));
            end else begin
                r = ops[$urandom_range(0, 5)];
            end
            run_instr(r, 1'($urandom), -1, 60);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control sequencer for the multi-cycle variant of the MIPS datapath. It replaces the single-cycle opcode decoder with a Moore state machine. The FSM steps each instruction through fetch, decode, execute, memory and write-back, reusing one ALU and one unified memory across cycles. It sits beside the register file, ALU and memory blocks and drives their enables and mux selects from the opcode and the ALU zero flag.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  Instruction[31:26] taken from the instruction register
- zero  in  1  ALU zero flag, valid in the BRANCH state
- mem_ready  in  1  memory completion handshake; used only with MC_WAIT_EN
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by zero (beq)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemToReg  out  1  write-back select: 1 = MDR, 0 = ALUOut
- RegDest  out  1  write address select: 1 = rd, 0 = rt
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  0 = rt, 1 = constant 4, 2 = signExtended, 3 = signExtended<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- illegal_op  out  1  one-cycle pulse on an unknown opcode
- state  out  4  current state encoding, for debug
- retired  out  CNT_W  count of completed instructions

## Operation
- States and encodings:
  - FETCH 0
  - DECODE 1
  - MEM_ADDR 2
  - MEM_READ 3
  - MEM_WB 4
  - MEM_WRITE 5
  - EXECUTE 6
  - R_WB 7
  - BRANCH 8
  - JUMP 9
  - ADDI_EX 10
  - ADDI_WB 11
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEM_ADDR (lw or sw), EXECUTE (R-type), BRANCH (beq), JUMP (j), ADDI_EX (addi); any other opcode -> FETCH.
  - MEM_ADDR -> MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ -> MEM_WB.
  - EXECUTE -> R_WB.
  - ADDI_EX -> ADDI_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP and ADDI_WB all -> FETCH.
- Outputs are Moore, decoded from the state register only. Every signal not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=1, IorD=0.
  - DECODE: ALUSrcB=3, to precompute the branch target.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=2.
  - MEM_READ: MemRead, IorD=1.
  - MEM_WB: RegWrite, MemToReg, RegDest=0.
  - MEM_WRITE: MemWrite, IorD=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - R_WB: RegWrite, RegDest=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=1.
  - JUMP: PCWrite, PCSource=2.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=2.
  - ADDI_WB: RegWrite, RegDest=0.
- illegal_op is asserted while in DECODE with an unsupported opcode. The instruction is dropped and the PC has already advanced by 4.
- retired increments by 1 in the last cycle of each instruction (MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB). A beq counts whether or not it is taken. retired wraps modulo 2^CNT_W. Illegal opcodes are not counted.

## Timing
- Reset:
  - While reset=1, all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) and illegal_op are forced to 0, and all selects are 0.
  - On the clock edge where reset=1, state is set to FETCH (0) and retired is set to 0.
  - Reset in any state aborts the instruction; no partial write-back occurs after the reset edge.
- Cycle counts per instruction, without wait states:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal 2
- The PC, IR and register file update on the rising edge that ends the state asserting the corresponding enable.

## Configuration
- MC_WAIT_EN defined:
  - FETCH, MEM_READ and MEM_WRITE hold their state, and keep their outputs, until mem_ready=1 is sampled.
  - PCWrite and IRWrite in FETCH are asserted only in the cycle where mem_ready=1, so the PC advances exactly once per fetch.
  - Each wait cycle adds one cycle to the instruction.
- MC_WAIT_EN undefined:
  - mem_ready is ignored.
  - Every state lasts exactly one cycle.

## Test plan
- Reset: hold reset for 2 cycles from an arbitrary state -> state=0, retired=0, all strobes 0 while reset is high; MemRead=1, IRWrite=1, PCWrite=1 in the first cycle after release.
- lw (opcode 100011) -> state sequence 0,1,2,3,4, back to 0 on cycle 6; RegWrite=1 with MemToReg=1 only in state 4; retired goes 0 -> 1.
- beq (000100) with zero=1 and again with zero=0 -> states 0,1,8; PCWriteCond=1 and PCSource=1 in state 8 in both runs; retired increments by 1 in both runs.
- Illegal opcode 111111 -> illegal_op pulses for exactly 1 cycle in state 1; next state is 0; retired is unchanged.
- Reset asserted while in MEM_WRITE during sw -> MemWrite=0 in that cycle; state=0 on the next edge.
- With MC_WAIT_EN, lw with mem_ready held low for 3 cycles in MEM_READ -> state stays at 3 for 4 cycles total; MemRead is held throughout; the instruction takes 8 cycles.
